// File: rtl/xor_accum_n.sv
// XOR datapath with a running XOR accumulator, valid/ready handshake and 1-cycle latency.
// Optional registered parity output is enabled by defining XOR_ACCUM_PARITY_EN.
module xor_accum_n #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
`ifdef XOR_ACCUM_PARITY_EN
  output logic             parity,
`endif
  output logic [CNT_W-1:0] acc_cnt
);

  localparam int unsigned NSLICE  = WIDTH / 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    MODE_XOR  = 2'b00,
    MODE_ACC  = 2'b01,
    MODE_LOAD = 2'b10,
    MODE_CLR  = 2'b11
  } mode_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] ab_x;
  logic [WIDTH-1:0] acc_x;
  logic [WIDTH-1:0] y_nxt;
  logic [WIDTH-1:0] acc_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             accept;

  // Quad-XOR slices: operand fold and accumulator fold, 4 bits each
  for (genvar s = 0; s < NSLICE; s++) begin : g_slice
    assign ab_x[4*s +: 4]  = a[4*s +: 4] ^ b[4*s +: 4];
    assign acc_x[4*s +: 4] = acc[4*s +: 4] ^ ab_x[4*s +: 4];
  end

  assign out_valid = (state == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;

  always_comb begin
    y_nxt   = ab_x;
    acc_nxt = acc;
    cnt_nxt = acc_cnt;
    case (mode_t'(mode))
      MODE_XOR: begin
        y_nxt = ab_x;
      end
      MODE_ACC: begin
        acc_nxt = acc_x;
        y_nxt   = acc_x;
        cnt_nxt = (acc_cnt == CNT_MAX) ? acc_cnt : acc_cnt + CNT_W'(1);
      end
      MODE_LOAD: begin
        acc_nxt = ab_x;
        y_nxt   = ab_x;
        cnt_nxt = CNT_W'(1);
      end
      MODE_CLR: begin
        acc_nxt = '0;
        y_nxt   = '0;
        cnt_nxt = '0;
      end
      default: ;
    endcase
  end

  // Output FSM and result registers; reset drops any pending or incoming word
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      y       <= '0;
      acc     <= '0;
      acc_cnt <= '0;
`ifdef XOR_ACCUM_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      case (state)
        EMPTY: if (accept) state <= FULL;
        FULL:  if (!accept && out_ready) state <= EMPTY;
        default: state <= EMPTY;
      endcase
      if (accept) begin
        y       <= y_nxt;
        acc     <= acc_nxt;
        acc_cnt <= cnt_nxt;
`ifdef XOR_ACCUM_PARITY_EN
        parity  <= ^y_nxt;
`endif
      end
    end
  end

endmodule

// File: tb/tb_xor_accum_n.sv
// Randomized and directed bench for xor_accum_n against a cycle-level behavioural model.
module tb_xor_accum_n;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 8;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic [CNT_W-1:0] acc_cnt;
`ifdef XOR_ACCUM_PARITY_EN
  logic             parity;
`endif

  always #5 clk = ~clk;

  xor_accum_n #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
`ifdef XOR_ACCUM_PARITY_EN
    .parity    (parity),
`endif
    .acc_cnt   (acc_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: what the consumer should see, derived from the operation rules
  logic             m_valid;
  logic [WIDTH-1:0] m_y;
  logic [WIDTH-1:0] m_acc;
  int               m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] md, input logic [7:0] aa, input logic [7:0] bb);
    in_valid = v;
    mode     = md;
    a        = aa;
    b        = bb;
  endtask

  // Advance one clock: update the model from the driven inputs, then compare after the edge
  task automatic cycle();
    logic take;
    take = in_valid && (!m_valid || out_ready);
    if (rst) begin
      m_valid = 1'b0;
      m_y     = '0;
      m_acc   = '0;
      m_cnt   = 0;
    end else if (take) begin
      case (mode)
        2'd0: m_y = a ^ b;
        2'd1: begin
          m_acc = m_acc ^ a ^ b;
          m_y   = m_acc;
          if (m_cnt < CNT_SAT) m_cnt = m_cnt + 1;
        end
        2'd2: begin
          m_acc = a ^ b;
          m_y   = m_acc;
          m_cnt = 1;
        end
        default: begin
          m_acc = '0;
          m_y   = '0;
          m_cnt = 0;
        end
      endcase
      m_valid = 1'b1;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check_eq("out_valid", 32'(out_valid), 32'(m_valid));
    check_eq("y", 32'(y), 32'(m_y));
    check_eq("acc_cnt", 32'(acc_cnt), 32'(m_cnt));
    check_eq("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
`ifdef XOR_ACCUM_PARITY_EN
    check_eq("parity", 32'(parity), 32'(^m_y));
`endif
  endtask

  initial begin
    m_valid   = 1'b0;
    m_y       = '0;
    m_acc     = '0;
    m_cnt     = 0;
    rst       = 1'b1;
    out_ready = 1'b0;
    drive(1'b1, 2'd1, 8'hAA, 8'h55);
    cycle();
    cycle();

    // First cycle out of reset: idle and ready
    rst = 1'b0;
    drive(1'b0, 2'd0, 8'h00, 8'h00);
    cycle();
    check_eq("ready_after_rst", 32'(in_ready), 32'd1);

    // Plain XOR after reset
    drive(1'b1, 2'd0, 8'h5A, 8'hFF);
    cycle();
    check_eq("xor_y", 32'(y), 32'hA5);
    check_eq("xor_cnt", 32'(acc_cnt), 32'd0);

    // LOAD then two ACC words
    out_ready = 1'b1;
    drive(1'b1, 2'd2, 8'h0F, 8'h00);
    cycle();
    check_eq("load_y", 32'(y), 32'h0F);
    drive(1'b1, 2'd1, 8'hF0, 8'h00);
    cycle();
    check_eq("acc1_y", 32'(y), 32'hFF);
    drive(1'b1, 2'd1, 8'h33, 8'h11);
    cycle();
    check_eq("acc2_y", 32'(y), 32'hDD);
    check_eq("acc2_cnt", 32'(acc_cnt), 32'd3);

    // Backpressure: nothing accepted while the consumer stalls
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd1, 8'($urandom), 8'($urandom));
      cycle();
      check_eq("stall_y", 32'(y), 32'hDD);
      check_eq("stall_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'd1, 8'($urandom), 8'($urandom));
      cycle();
    end
    check_eq("release_cnt", 32'(acc_cnt), 32'd7);

    // Counter saturation while the accumulator keeps toggling
    drive(1'b1, 2'd2, 8'h00, 8'h00);
    cycle();
    for (int i = 1; i <= 300; i++) begin
      drive(1'b1, 2'd1, 8'h01, 8'h00);
      cycle();
    end
    check_eq("sat_cnt", 32'(acc_cnt), 32'd255);
    check_eq("sat_y", 32'(y), 32'h00);
    drive(1'b1, 2'd1, 8'h01, 8'h00);
    cycle();
    check_eq("sat_y_odd", 32'(y), 32'h01);

    // Random traffic with occasional resets and idle don't-care operands
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 63) == 0);
      out_ready = 1'($urandom_range(0, 3) != 0);
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom), 8'($urandom));
      cycle();
    end
    rst = 1'b0;

    // Reset while a word is pending and another is being accepted
    out_ready = 1'b0;
    drive(1'b1, 2'd2, 8'h3C, 8'h00);
    cycle();
    out_ready = 1'b1;
    rst       = 1'b1;
    drive(1'b1, 2'd2, 8'h77, 8'h00);
    cycle();
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_y", 32'(y), 32'h00);
    check_eq("rst_cnt", 32'(acc_cnt), 32'd0);
    rst = 1'b0;
    drive(1'b0, 2'd0, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("rst_no_ghost", 32'(out_valid), 32'd0);
    end

`ifdef XOR_ACCUM_PARITY_EN
    drive(1'b1, 2'd0, 8'h07, 8'h00);
    cycle();
    check_eq("parity_odd", 32'(parity), 32'd1);
    drive(1'b1, 2'd0, 8'h03, 8'h00);
    cycle();
    check_eq("parity_even", 32'(parity), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
